xbar_slave_mem_model: RTL and testbench
=======================================

XBAR_SLAVE_MEM_MODEL -- requirements
Module: xbar_slave_mem_model

Interface
REQ-001 SHALL have parameter MEMSIZE32, default 1024: memory depth in 32-bit words, power of two.
REQ-002 SHALL have parameter RESP_DEPTH, default 4: read-response buffer depth in entries, power of two.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port slave_req, input, 1 bit: request valid.
REQ-006 SHALL have port slave_addr, input, 32 bits: byte address.
REQ-007 SHALL have port slave_cmd, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port slave_wdata, input, 32 bits: write data.
REQ-009 SHALL have port slave_ack, output, 1 bit: request accepted this cycle.
REQ-010 SHALL have port slave_rdata, output, 32 bits: read response data.
REQ-011 SHALL have port slave_resp, output, 1 bit: read response valid, one cycle per response.
REQ-012 SHALL hold storage in an array named mem, MEMSIZE32 x 32 bits, readable by hierarchical reference from a bench.

Function
REQ-013 slave_ack SHALL be combinational: slave_req AND response buffer not full; it SHALL be 0 while rst_i=0.
REQ-014 A request SHALL be accepted in a cycle where slave_req=1 and slave_ack=1; the master holds addr/cmd/wdata stable until accepted.
REQ-015 The word index SHALL be slave_addr[log2(MEMSIZE32)+1:2]; bits [1:0] and the upper address bits SHALL be ignored, with no range error.
REQ-016 An accepted write SHALL update mem[index] with slave_wdata at the accepting clock edge, with no byte enables and no response.
REQ-017 An accepted read SHALL push mem[index], sampled before any write at the same edge, into the in-order response FIFO at the accepting edge.
REQ-018 When the FIFO is non-empty, slave_resp SHALL be 1 with slave_rdata set to the head entry, and the head SHALL pop at that edge (one response per cycle, no backpressure).
REQ-019 Minimum read latency SHALL be one cycle: a read accepted at edge N gives slave_resp=1 during cycle N+1.
REQ-020 If the FIFO is full and pops in the same cycle, slave_ack SHALL still be 0; pushes are allowed only when occupancy < RESP_DEPTH before the edge.
REQ-021 With simultaneous push and pop, occupancy SHALL be unchanged; FIFO pointers SHALL wrap modulo RESP_DEPTH.
REQ-022 Responses SHALL be returned in strict request order; a read after a write to the same word SHALL return the written value.
REQ-023 When slave_resp=0, slave_rdata SHALL hold its last value.

Reset
REQ-024 rst_i=0 SHALL asynchronously empty the FIFO, force slave_resp=0 and slave_rdata=0, and drop any queued responses, including mid-operation.
REQ-025 Reset SHALL NOT alter mem contents; uninitialised words read as X in simulation.

Structure
REQ-026 A shared package SHALL hold the 32-bit address/data width constants and the command encoding (WRITE=1, READ=0).
REQ-027 The response FIFO SHALL be a sub-module named resp_fifo, parameterised by width and depth, with full, empty, push and pop signals.

Verification
REQ-028 Write addr 0x10, wdata 0x4000_0010, then read 0x10 -> slave_resp one cycle after ack, rdata 0x4000_0010; mem[4]=0x4000_0010.
REQ-029 Hold slave_req=1 on reads to 0x0..0xC in back-to-back cycles -> four acks, then four consecutive resp cycles with data in order.
REQ-030 Fill the FIFO (stall the response path by forcing the buffer full) -> slave_ack=0 on the 5th read until a pop frees an entry.
REQ-031 Write addr 0xC000_1004 with MEMSIZE32=1024 -> mem[1] updated, because upper bits are ignored.
REQ-032 Assert rst_i=0 with two reads queued -> slave_resp=0 immediately with no later responses, and mem contents unchanged.
REQ-033 Init all 1024 words to (3<<30)+(i<<2), then read every word -> every response matches and the mem array check passes.

Source files
------------

// File: rtl/xbar_slave_mem_model_pkg.sv
// Shared widths and command encoding for the crossbar slave memory model.
package xbar_slave_mem_model_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic {
      CMD_READ  = 1'b0,
      CMD_WRITE = 1'b1
   } cmd_e;
endpackage

// File: rtl/xbar_slave_mem_model_resp_fifo.sv
// In-order read-response FIFO; head entry is visible combinationally.
module resp_fifo
   import xbar_slave_mem_model_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_buf [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign full      = (r_count == (PW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;
   assign head_data = r_buf[r_rd_ptr];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop_ok)
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (w_push_ok)
         r_buf[r_wr_ptr] <= push_data;
   end
endmodule

// File: rtl/xbar_slave_mem_model.sv
// Word-addressed slave memory with single-cycle accept and in-order read responses.
module xbar_slave_mem_model
   import xbar_slave_mem_model_pkg::*;
#(
   parameter int MEMSIZE32  = 1024,
   parameter int RESP_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              slave_req,
   input  logic [ADDR_W-1:0] slave_addr,
   input  logic              slave_cmd,
   input  logic [DATA_W-1:0] slave_wdata,
   output logic              slave_ack,
   output logic [DATA_W-1:0] slave_rdata,
   output logic              slave_resp
);
   localparam int IDX_W = $clog2(MEMSIZE32);

   logic [DATA_W-1:0] mem [MEMSIZE32];

   logic [IDX_W-1:0]  w_idx;
   logic              w_wr;
   logic              w_rd;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_head;
   logic              w_unused_addr_bits;
   logic [DATA_W-1:0] r_last_rdata;

   // Upper and byte-lane address bits alias onto the same word.
   assign w_idx              = slave_addr[IDX_W+1:2];
   assign w_unused_addr_bits = ^{slave_addr[ADDR_W-1:IDX_W+2], slave_addr[1:0]};

   assign slave_ack = slave_req & ~w_full & rst_i;
   assign w_wr      = slave_ack & (slave_cmd == CMD_WRITE);
   assign w_rd      = slave_ack & (slave_cmd == CMD_READ);

   always_ff @(posedge clk_i) begin
      if (w_wr)
         mem[w_idx] <= slave_wdata;
   end

   resp_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (w_rd),
      .push_data (mem[w_idx]),
      .pop       (~w_empty),
      .head_data (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   // The head is presented and popped every cycle the FIFO holds data.
   assign slave_resp  = ~w_empty;
   assign slave_rdata = w_empty ? r_last_rdata : w_head;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_last_rdata <= '0;
      else if (!w_empty)
         r_last_rdata <= w_head;
   end
endmodule

// File: tb/tb_xbar_slave_mem_model.sv
// Randomised and directed bench for xbar_slave_mem_model against a queue/array reference.
module tb_xbar_slave_mem_model;
   logic        clk_i       = 1'b0;
   logic        rst_i       = 1'b0;
   logic        slave_req   = 1'b0;
   logic [31:0] slave_addr  = 32'h0;
   logic        slave_cmd   = 1'b0;
   logic [31:0] slave_wdata = 32'h0;
   logic        slave_ack;
   logic [31:0] slave_rdata;
   logic        slave_resp;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] model_mem [1024];
   logic [31:0] exp_q [$];
   logic [31:0] last_rdata = 32'h0;

   xbar_slave_mem_model #(
      .MEMSIZE32  (1024),
      .RESP_DEPTH (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .slave_req   (slave_req),
      .slave_addr  (slave_addr),
      .slave_cmd   (slave_cmd),
      .slave_wdata (slave_wdata),
      .slave_ack   (slave_ack),
      .slave_rdata (slave_rdata),
      .slave_resp  (slave_resp)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #400000;
      $display("FAIL timeout: observed no finish, expected finish before 400000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive at the falling edge, check mid-cycle, advance the model
   // to the state after the next rising edge.
   task automatic step(input logic req, input logic cmd, input logic [31:0] addr,
                       input logic [31:0] wdata);
      int          idx;
      logic        exp_resp;
      logic [31:0] exp_rdata;
      slave_req   = req;
      slave_cmd   = cmd;
      slave_addr  = addr;
      slave_wdata = wdata;
      #1;
      idx       = int'((addr >> 2) % 32'd1024);
      exp_resp  = (exp_q.size() > 0);
      exp_rdata = exp_resp ? exp_q[0] : last_rdata;
      chk("ack", 32'(slave_ack), 32'(req));
      chk("resp", 32'(slave_resp), 32'(exp_resp));
      chk("rdata", slave_rdata, exp_rdata);
      $display("step req=%0d cmd=%0d addr=%h wdata=%h ack=%0d resp=%0d rdata=%h",
               req, cmd, addr, wdata, slave_ack, slave_resp, slave_rdata);
      if (exp_resp)
         last_rdata = exp_q.pop_front();
      if (req) begin
         if (cmd)
            model_mem[idx] = wdata;
         else
            exp_q.push_back(model_mem[idx]);
      end
      @(negedge clk_i);
   endtask

   task automatic check_mem(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++)
         if (dut.mem[i] !== model_mem[i])
            bad++;
      chk(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      // Reset state, with a request already asserted.
      rst_i     = 1'b0;
      slave_req = 1'b1;
      #2;
      chk("rst_ack", 32'(slave_ack), 32'd0);
      chk("rst_resp", 32'(slave_resp), 32'd0);
      chk("rst_rdata", slave_rdata, 32'd0);
      slave_req = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;

      // Write then read back the same word.
      step(1'b1, 1'b1, 32'h0000_0010, 32'h4000_0010);
      step(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      chk("mem4", dut.mem[4], 32'h4000_0010);

      // Upper address bits alias onto word 1.
      step(1'b1, 1'b1, 32'hC000_1004, 32'hDEAD_BEEF);
      chk("mem1_alias", dut.mem[1], 32'hDEAD_BEEF);

      // Fill the whole array through the port.
      for (int i = 0; i < 1024; i++)
         step(1'b1, 1'b1, 32'(i) << 2, (32'd3 << 30) + (32'(i) << 2));

      // Back-to-back reads of the first four words.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 32'(i) << 2, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);

      // Read every word, with junk in the ignored address bits.
      for (int i = 0; i < 1024; i++)
         step(1'b1, 1'b0, {$urandom_range(0, 1048575) , 12'h0} | (32'(i) << 2) | 32'($urandom_range(0, 3)), 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check_mem("mem_array_init");

      // A full response buffer must block acceptance.
      slave_req  = 1'b1;
      slave_cmd  = 1'b0;
      slave_addr = 32'h0;
      force dut.w_full = 1'b1;
      #1;
      chk("ack_when_full", 32'(slave_ack), 32'd0);
      release dut.w_full;
      #1;
      chk("ack_after_free", 32'(slave_ack), 32'd1);
      slave_req = 1'b0;
      @(negedge clk_i);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r;
         r = $urandom;
         step(r[0] | r[1], r[2], $urandom, $urandom);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0);

      // Reset with a response in flight.
      step(1'b1, 1'b0, 32'h0000_0020, 32'h0);
      step(1'b1, 1'b0, 32'h0000_0024, 32'h0);
      slave_req  = 1'b1;
      slave_cmd  = 1'b0;
      slave_addr = 32'h0000_0028;
      rst_i      = 1'b0;
      #1;
      chk("midrst_resp", 32'(slave_resp), 32'd0);
      chk("midrst_rdata", slave_rdata, 32'd0);
      chk("midrst_ack", 32'(slave_ack), 32'd0);
      exp_q.delete();
      last_rdata = 32'h0;
      @(negedge clk_i);
      chk("midrst_resp_hold", 32'(slave_resp), 32'd0);
      rst_i     = 1'b1;
      slave_req = 1'b0;
      repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
      check_mem("mem_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
